// File: rtl/pattern_scan_ctrl.sv
// Serial "101" pattern scanner: loads a word on start, shifts it out MSB-first
// through an overlapping "101" detector and reports the match count with a done pulse.
module pattern_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             serial_out,
    output logic             hit
);

    // Handshake: start is a request honoured only while busy=0 (IDLE); the word is
    // captured on that edge, busy rises the next cycle, and done pulses for one cycle
    // WIDTH+1 cycles after acceptance, with match_count valid from then until the next start.

    localparam int BC_W = $clog2(WIDTH);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_SHIFT = 2'd1;
    localparam logic [1:0] C_DONE  = 2'd2;

    localparam logic [1:0] D_S0  = 2'd0;
    localparam logic [1:0] D_S1  = 2'd1;
    localparam logic [1:0] D_S10 = 2'd2;

    localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       ctrl_state;
    logic [1:0]       det_state;
    logic [1:0]       det_next;
    logic [WIDTH-1:0] shift_reg;
    logic [BC_W-1:0]  bit_cnt;
    logic             in_shift;

    assign in_shift   = (ctrl_state == C_SHIFT);
    assign busy       = (ctrl_state == C_SHIFT) || (ctrl_state == C_DONE);
    assign done       = (ctrl_state == C_DONE);
    assign serial_out = in_shift ? shift_reg[WIDTH-1] : 1'b0;
    assign hit        = in_shift && (det_state == D_S10) && serial_out;

    always_comb begin
        det_next = D_S0;
        case (det_state)
            D_S0:    det_next = serial_out ? D_S1 : D_S0;
            D_S1:    det_next = serial_out ? D_S1 : D_S10;
            D_S10:   det_next = serial_out ? D_S1 : D_S0;
            default: det_next = D_S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_state  <= C_IDLE;
            det_state   <= D_S0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            match_count <= '0;
        end else begin
            case (ctrl_state)
                C_IDLE: begin
                    if (start) begin
                        shift_reg   <= data_in;
                        match_count <= '0;
                        det_state   <= D_S0;
                        bit_cnt     <= '0;
                        ctrl_state  <= C_SHIFT;
                    end
                end
                C_SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    det_state <= det_next;
                    bit_cnt   <= bit_cnt + BC_W'(1);
                    if (hit && (match_count != CNT_MAX)) begin
                        match_count <= match_count + CNT_W'(1);
                    end
                    if (bit_cnt == LAST_BIT) begin
                        ctrl_state <= C_DONE;
                    end
                end
                C_DONE: begin
                    ctrl_state <= C_IDLE;
                end
                default: begin
                    ctrl_state <= C_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: directed and random words scanned by a default
// instance and a CNT_W=1 instance, checked against a bit-pattern reference model.
module tb_pattern_scan_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data_in;

    logic       a_busy, a_done, a_serial, a_hit;
    logic [3:0] a_count;
    logic       b_busy, b_done, b_serial, b_hit;
    logic [0:0] b_count;

    int tests_run    = 0;
    int tests_failed = 0;

    pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(a_busy), .done(a_done), .match_count(a_count),
        .serial_out(a_serial), .hit(a_hit)
    );

    pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(1)) dut_b (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in),
        .busy(b_busy), .done(b_done), .match_count(b_count),
        .serial_out(b_serial), .hit(b_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bit presented in SHIFT cycle k (1-based), MSB first.
    function automatic logic ref_bit(input logic [WIDTH-1:0] w, input int k);
        return w[WIDTH-k];
    endfunction

    // Cycle k completes a match when the last three presented bits read 1,0,1.
    function automatic logic ref_hit(input logic [WIDTH-1:0] w, input int k);
        if (k < 3) return 1'b0;
        return w[WIDTH-k+2] && !w[WIDTH-k+1] && w[WIDTH-k];
    endfunction

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_a_serial"}, a_serial, 0);
        chk({tag, "_a_hit"}, a_hit, 0);
        chk({tag, "_b_serial"}, b_serial, 0);
        chk({tag, "_b_hit"}, b_hit, 0);
    endtask

    // Entered at a negedge with the DUT idle; leaves at the negedge of cycle WIDTH+2.
    task automatic scan(input logic [WIDTH-1:0] w, input bit stray);
        int run;
        run     = 0;
        data_in = w;
        start   = 1'b1;
        for (int k = 1; k <= WIDTH; k++) begin
            @(negedge clk);
            chk("shift_a_busy", a_busy, 1);
            chk("shift_a_done", a_done, 0);
            chk("shift_a_serial", a_serial, ref_bit(w, k));
            chk("shift_a_hit", a_hit, ref_hit(w, k));
            chk("shift_a_count", a_count, sat(run, 15));
            chk("shift_b_hit", b_hit, ref_hit(w, k));
            chk("shift_b_count", b_count, sat(run, 1));
            if (ref_hit(w, k)) run++;
            start = 1'b0;
            if (stray && k == 4) begin
                start   = 1'b1;
                data_in = ~w;
            end
        end
        @(negedge clk);
        chk("done_a_done", a_done, 1);
        chk("done_a_busy", a_busy, 1);
        chk("done_a_count", a_count, sat(run, 15));
        chk("done_b_done", b_done, 1);
        chk("done_b_count", b_count, sat(run, 1));
        chk_idle_outputs("done");
        start = 1'b0;
        if (stray) begin
            start   = 1'b1;
            data_in = ~w;
        end
        @(negedge clk);
        chk("after_a_done", a_done, 0);
        chk("after_a_busy", a_busy, 0);
        chk("after_a_count", a_count, sat(run, 15));
        chk("after_b_busy", b_busy, 0);
        chk("after_b_count", b_count, sat(run, 1));
        chk_idle_outputs("after");
        start = 1'b0;
    endtask

    // Reset lands on the edge ending SHIFT cycle abort_k; leaves at negedge of the next cycle.
    task automatic scan_abort(input logic [WIDTH-1:0] w, input int abort_k);
        data_in = w;
        start   = 1'b1;
        for (int k = 1; k <= abort_k; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk("abort_a_busy", a_busy, 1);
            chk("abort_a_serial", a_serial, ref_bit(w, k));
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_a_busy_after", a_busy, 0);
        chk("abort_a_done_after", a_done, 0);
        chk("abort_a_count_after", a_count, 0);
        chk("abort_b_done_after", b_done, 0);
        chk("abort_b_count_after", b_count, 0);
        chk_idle_outputs("abort");
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        reset   = 1'b1;
        start   = 1'b1;
        data_in = 8'b1010_0000;
        repeat (3) begin
            @(negedge clk);
            chk("reset_a_busy", a_busy, 0);
            chk("reset_a_done", a_done, 0);
            chk("reset_a_count", a_count, 0);
            chk("reset_b_busy", b_busy, 0);
            chk("reset_b_count", b_count, 0);
            chk_idle_outputs("reset");
        end
        reset = 1'b0;
        start = 1'b0;

        scan(8'b1010_0000, 1'b0);
        scan(8'b1010_1010, 1'b0);
        scan(8'b1101_1011, 1'b0);
        scan(8'h00, 1'b0);
        scan(8'b1010_1010, 1'b1);
        scan(8'b1010_0000, 1'b0);
        scan_abort(8'b1010_1010, 5);
        scan(8'b1010_0000, 1'b0);
        scan(8'hFF, 1'b0);
        scan(8'b1011_0101, 1'b1);

        for (int i = 0; i < 40; i++) begin
            w = WIDTH'($urandom);
            scan(w, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the number of bits per scanned word (minimum 3).
REQ-002 SHALL have parameter CNT_W, default 4, giving the width of the match counter (minimum 1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to scan data_in; sampled only in IDLE.
REQ-006 SHALL have port data_in  input  WIDTH  word to scan, captured on the accepting edge.
REQ-007 SHALL have port busy  output  1  high in SHIFT and DONE.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-009 SHALL have port match_count  output  CNT_W  number of "101" matches in the last scanned word.
REQ-010 SHALL have port serial_out  output  1  bit currently presented to the detector (MSB of the shift register).
REQ-011 SHALL have port hit  output  1  high in the cycle whose serial_out bit completes a "101" pattern.

Function
REQ-012 SHALL implement a control FSM with states IDLE, SHIFT, DONE.
REQ-013 SHALL implement an internal detector FSM with states S0, S1, S10, tracking the serial stream MSB-first.
REQ-014 SHALL, in IDLE with start=1, load data_in into the shift register, clear match_count to 0, force the detector to S0, clear the bit counter, and enter SHIFT on that edge.
REQ-015 SHALL ignore start in SHIFT and DONE; no reload, no count change.
REQ-016 SHALL, in SHIFT, present one bit per cycle on serial_out, shift left by one each edge, and consume exactly WIDTH bits over WIDTH consecutive cycles.
REQ-017 SHALL use these detector transitions on bit b: S0: b=1 to S1, else S0; S1: b=0 to S10, else S1; S10: b=1 to S1 with hit, else S0.
REQ-018 SHALL count overlapping matches, so 10101 yields 2.
REQ-019 SHALL assert hit combinationally only in SHIFT, when state=S10 and serial_out=1.
REQ-020 SHALL increment match_count on the edge ending each hit cycle.
REQ-021 SHALL saturate match_count at 2^CNT_W-1, with no wrap.
REQ-022 SHALL enter DONE on the edge ending the WIDTH-th SHIFT cycle, hold done=1 for exactly that one DONE cycle, then return to IDLE.
REQ-023 SHALL provide this latency: start accepted at edge 0; SHIFT cycles 1..WIDTH; done in cycle WIDTH+1; start is accepted again from cycle WIDTH+2.
REQ-024 SHALL hold match_count stable from the DONE cycle until the next accepted start.
REQ-025 SHALL NOT carry detector state between words; every word starts in S0.
REQ-026 SHALL drive serial_out=0 and hit=0 outside SHIFT.

Reset
REQ-027 SHALL, with reset=1 at a clock edge, set control FSM to IDLE, detector to S0, shift register, bit counter and match_count to 0, and done and busy to 0.
REQ-028 SHALL let reset override start and any in-progress SHIFT or DONE, with no done pulse from an aborted scan.
REQ-029 SHALL accept start in the first cycle after reset deasserts.

Verification
REQ-030 SHALL cover: WIDTH=8, start with data_in=8'b10100000 -> hit in SHIFT cycle 3, done in cycle 9, match_count=1.
REQ-031 SHALL cover: data_in=8'b10101010 -> hits in SHIFT cycles 3, 5, 7, match_count=3 (overlap).
REQ-032 SHALL cover: data_in=8'b11011011 -> match_count=2; then data_in=8'h00 -> match_count=0, confirming no carry-over.
REQ-033 SHALL cover: start pulsed in SHIFT cycle 4 and in the DONE cycle with different data -> ignored, result unchanged; start in cycle 10 is accepted.
REQ-034 SHALL cover: reset asserted in SHIFT cycle 5 -> next cycle busy=0, match_count=0, no done; fresh scan of 8'b10100000 gives 1.
REQ-035 SHALL cover: CNT_W=1 with data_in=8'b10101010 -> match_count saturates at 1.
